// File: rtl/nic.sv
// Network interface: one-entry input buffer plus CPU-writable output channel.
// Define NIC_OUT_FIFO_EN to make the output channel a 2-entry FIFO (default: single entry).
module nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ro,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ri,
    output logic [0:DATA_WIDTH-1] net_do
);

    localparam logic [0:1] AddrInBuf  = 2'b00;
    localparam logic [0:1] AddrInStat = 2'b01;
    localparam logic [0:1] AddrOutBuf = 2'b10;
    localparam logic [0:1] AddrOutStat = 2'b11;

    // Status words carry their flag in the last (least significant) bit position.
    function automatic logic [0:DATA_WIDTH-1] statusWord(input logic flag);
        return {{(DATA_WIDTH-1){1'b0}}, flag};
    endfunction

    logic                  inFull;
    logic [0:DATA_WIDTH-1] inBuf;
    logic                  outFull;
    logic                  cpuRead;
    logic                  cpuWrite;
    logic                  outEnq;
    logic                  outDeq;

    assign cpuRead  = nicEn && !nicWrEn;
    assign cpuWrite = nicEn && nicWrEn;
    assign net_ro   = !inFull;
    assign outEnq   = cpuWrite && (addr == AddrOutBuf) && !outFull;
    assign outDeq   = net_so && net_ri;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out  <= '0;
            inFull <= 1'b0;
            inBuf  <= '0;
        end else begin
            if (cpuRead) begin
                case (addr)
                    AddrInBuf:   d_out <= inFull ? inBuf : '0;
                    AddrInStat:  d_out <= statusWord(inFull);
                    AddrOutStat: d_out <= statusWord(outFull);
                    default:     d_out <= '0;
                endcase
            end
            // net_ro is low while full, so a freeing read never coincides with a landing packet.
            if (cpuRead && (addr == AddrInBuf) && inFull)
                inFull <= 1'b0;
            if (net_si && net_ro) begin
                inBuf  <= net_di;
                inFull <= 1'b1;
            end
        end
    end

`ifdef NIC_OUT_FIFO_EN
    logic [1:0]            outCnt;
    logic [0:DATA_WIDTH-1] outBuf0;
    logic [0:DATA_WIDTH-1] outBuf1;

    assign outFull = (outCnt == 2'd2);
    assign net_so  = (outCnt != 2'd0);
    assign net_do  = outBuf0;

    // outBuf0 is always the head; a dequeue shifts outBuf1 forward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outCnt  <= 2'd0;
            outBuf0 <= '0;
            outBuf1 <= '0;
        end else begin
            case ({outEnq, outDeq})
                2'b11: outBuf0 <= (outCnt == 2'd1) ? d_in : outBuf1;
                2'b01: begin
                    outBuf0 <= outBuf1;
                    outBuf1 <= '0;
                    outCnt  <= outCnt - 2'd1;
                end
                2'b10: begin
                    if (outCnt == 2'd0)
                        outBuf0 <= d_in;
                    else
                        outBuf1 <= d_in;
                    outCnt <= outCnt + 2'd1;
                end
                default: ;
            endcase
        end
    end
`else
    logic                  outValid;
    logic [0:DATA_WIDTH-1] outBuf;

    assign outFull = outValid;
    assign net_so  = outValid;
    assign net_do  = outBuf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid <= 1'b0;
            outBuf   <= '0;
        end else if (outEnq) begin
            outBuf   <= d_in;
            outValid <= 1'b1;
        end else if (outDeq) begin
            outValid <= 1'b0;
        end
    end
`endif

endmodule
